// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// Bundles the three buses around mem_ctrl:
//   - instruction fetch : if_req, if_addr, if_flush -> if_inst, if_done
//   - load/store        : mem_req, mem_we, mem_len, mem_sign, mem_addr,
//                         mem_wdata -> mem_rdata, mem_done
//   - byte-wide RAM     : ram_a, ram_wr, ram_dout -> ram_din (1-cycle latency)
// Modports:
//   slave  : the controller (consumes requests, masters the RAM port)
//   master : the surroundings (requesters plus the RAM itself)
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  if_req;
  logic [31:0]           if_addr;
  logic                  if_flush;
  logic [31:0]           if_inst;
  logic                  if_done;

  logic                  mem_req;
  logic                  mem_we;
  logic [1:0]            mem_len;
  logic                  mem_sign;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_done;

  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_wr;
  logic [7:0]            ram_dout;
  logic [7:0]            ram_din;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_inst, if_done,
    input  mem_req, mem_we, mem_len, mem_sign, mem_addr, mem_wdata,
    output mem_rdata, mem_done,
    output ram_a, ram_wr, ram_dout,
    input  ram_din
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_inst, if_done,
    output mem_req, mem_we, mem_len, mem_sign, mem_addr, mem_wdata,
    input  mem_rdata, mem_done,
    input  ram_a, ram_wr, ram_dout,
    output ram_din
  );
endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Shares one byte-wide synchronous RAM port between instruction fetch and
// load/store. Each 1/2/4-byte access is split into single-byte RAM cycles,
// little-endian words are assembled/disassembled, loads are sign- or
// zero-extended, and each requester gets a one-cycle done pulse.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : mem_ctrl_if.slave (fetch, load/store and RAM signals)
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_e                state_q,     state_d;
  logic                  owner_if_q,  owner_if_d;   // 1 = fetch owns the transfer
  logic [2:0]            len_q,       len_d;        // bytes in transfer: 1, 2 or 4
  logic [2:0]            cnt_q,       cnt_d;        // cycle index within READ/WRITE
  logic                  sign_q,      sign_d;
  logic [31:0]           wbuf_q,      wbuf_d;       // store bytes still to send
  logic [31:0]           rbuf_q,      rbuf_d;       // load bytes collected so far
  logic [ADDR_WIDTH-1:0] ram_a_q,     ram_a_d;
  logic                  ram_wr_q,    ram_wr_d;
  logic [7:0]            ram_dout_q,  ram_dout_d;
  logic                  if_done_q,   if_done_d;
  logic                  mem_done_q,  mem_done_d;
  logic [31:0]           if_inst_q,   if_inst_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;

  // Upper address bits beyond the RAM are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_WIDTH], bus.mem_addr[31:ADDR_WIDTH]};

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b00:   len_bytes = 3'd1;
      2'b01:   len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

  // Read bytes are shifted in from the top, so an N-byte load ends up
  // left-justified in the buffer: byte at [31:24], half at [31:16].
  function automatic logic [31:0] extend(input logic [31:0] shifted,
                                         input logic [2:0]  n,
                                         input logic        sgn);
    case (n)
      3'd1:    extend = {{24{sgn & shifted[31]}}, shifted[31:24]};
      3'd2:    extend = {{16{sgn & shifted[31]}}, shifted[31:16]};
      default: extend = shifted;
    endcase
  endfunction

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    owner_if_d  = owner_if_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    wbuf_d      = wbuf_q;
    rbuf_d      = rbuf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          owner_if_d = 1'b0;
          len_d      = len_bytes(bus.mem_len);
          sign_d     = bus.mem_sign;
          ram_a_d    = bus.mem_addr[ADDR_WIDTH-1:0];
          cnt_d      = 3'd0;
          rbuf_d     = '0;
          if (bus.mem_we) begin
            // First byte goes out with the first WRITE cycle.
            state_d    = WRITE;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.mem_wdata[7:0];
            wbuf_d     = {8'h00, bus.mem_wdata[31:8]};
          end else begin
            state_d = READ;
          end
        end else if (bus.if_req && !bus.if_flush) begin
          owner_if_d = 1'b1;
          len_d      = 3'd4;
          sign_d     = 1'b0;
          ram_a_d    = bus.if_addr[ADDR_WIDTH-1:0];
          cnt_d      = 3'd0;
          rbuf_d     = '0;
          state_d    = READ;
        end
      end

      READ: begin
        if (owner_if_q && bus.if_flush) begin
          // Redirect: drop the fetch, ram_a simply holds.
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          // ram_din reflects the address driven one cycle earlier.
          if (cnt_q != 3'd0) begin
            rbuf_d = {bus.ram_din, rbuf_q[31:8]};
          end
          if ((cnt_q + 3'd1) < len_q) begin
            ram_a_d = ram_a_q + ADDR_ONE;
          end
          if (cnt_q == len_q) begin
            state_d = DONE;
            if (owner_if_q) begin
              if_done_d = 1'b1;
              if_inst_d = rbuf_d;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = extend(rbuf_d, len_q, sign_q);
            end
          end
        end
      end

      WRITE: begin
        if ((cnt_q + 3'd1) == len_q) begin
          state_d     = DONE;
          mem_done_d  = 1'b1;
          mem_rdata_d = '0;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          ram_wr_d   = 1'b1;
          ram_a_d    = ram_a_q + ADDR_ONE;
          ram_dout_d = wbuf_q[7:0];
          wbuf_d     = {8'h00, wbuf_q[31:8]};
        end
      end

      DONE: begin
        // Requests still high here are ignored; they are re-sampled in IDLE.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from the values computed before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_if_q  <= 1'b0;
      len_q       <= 3'd0;
      cnt_q       <= 3'd0;
      sign_q      <= 1'b0;
      wbuf_q      <= '0;
      rbuf_q      <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'h00;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_if_q  <= owner_if_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      wbuf_q      <= wbuf_d;
      rbuf_q      <= rbuf_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // A flush arriving during the DONE cycle itself must still cancel the
  // fetch pulse, so the registered pulse is gated by the live flush.
  assign bus.if_done   = if_done_q & ~bus.if_flush;
  assign bus.if_inst   = if_inst_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.ram_a     = ram_a_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Self-checking bench for mem_ctrl. A byte RAM array with one-cycle read
// latency sits on the RAM port; a separate byte array holds the expected
// memory contents and expected load values are computed from it directly.
// Cycle 0 is the IDLE cycle in which a request is first presented.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;
  localparam int AW    = 17;
  localparam int MSIZE = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();
  mem_ctrl    #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] ram   [MSIZE];
  logic [7:0] model [MSIZE];

  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_a] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_a];
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] tr_a  [0:24];
  logic          tr_wr [0:24];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx(input logic [31:0] a, input int k);
    return int'((a + 32'(k)) % 32'(MSIZE));
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input int n, input bit sgn);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w = w | (32'(model[idx(a, k)]) << (8 * k));
    if (sgn && n < 4 && w[8*n-1]) w = w | (32'hFFFF_FFFF << (8 * n));
    return w;
  endfunction

  task automatic set_byte(input int a, input logic [7:0] v);
    ram[a]   = v;
    model[a] = v;
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0; bus.if_addr  = '0; bus.if_flush = 1'b0;
    bus.mem_req  = 1'b0; bus.mem_we   = 1'b0; bus.mem_len = 2'b00;
    bus.mem_sign = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Drives one request and waits (bounded) for its done pulse; leaves the DUT
  // back in IDLE. done_c = -1 on timeout.
  task automatic run_op(input bit is_if, input bit we, input logic [1:0] len,
                        input bit sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        output int done_c, output logic [31:0] data, output bit other);
    done_c = -1; data = 'x; other = 1'b0;
    if (is_if) begin
      bus.if_addr = addr; bus.if_req = 1'b1;
    end else begin
      bus.mem_we = we; bus.mem_len = len; bus.mem_sign = sgn;
      bus.mem_addr = addr; bus.mem_wdata = wdata; bus.mem_req = 1'b1;
    end
    for (int c = 1; c <= 24; c++) begin
      tick();
      tr_a[c]  = bus.ram_a;
      tr_wr[c] = bus.ram_wr;
      if (is_if ? bus.mem_done : bus.if_done) other = 1'b1;
      if (is_if && bus.if_done) begin
        done_c = c; data = bus.if_inst; bus.if_req = 1'b0; break;
      end
      if (!is_if && bus.mem_done) begin
        done_c = c; data = bus.mem_rdata; bus.mem_req = 1'b0; break;
      end
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    tick(); tick(); tick();
    n_checks++;
    if ({bus.ram_wr, bus.if_done, bus.mem_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.ram_wr, bus.if_done, bus.mem_done});
    end
    n_checks++;
    if ({bus.if_inst, bus.mem_rdata, bus.ram_dout} !== '0 || bus.ram_a !== '0) begin
      n_fail++; $display("FAIL reset_data: inst=%h rdata=%h a=%h dout=%h expected all 0",
                         bus.if_inst, bus.mem_rdata, bus.ram_a, bus.ram_dout);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int dc; logic [31:0] d; bit oth;
    set_byte(32'h100, 8'h11); set_byte(32'h101, 8'h22);
    set_byte(32'h102, 8'h33); set_byte(32'h103, 8'h44);
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, '0, dc, d, oth);
    n_checks++;
    if (dc !== 6) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 6", dc); end
    n_checks++;
    if (d !== 32'h4433_2211) begin n_fail++; $display("FAIL fetch_data: got %h expected 44332211", d); end
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (tr_a[c] !== AW'(32'h100 + c - 1) || tr_wr[c] !== 1'b0) begin
        n_fail++; $display("FAIL fetch_addr_c%0d: got a=%h wr=%b expected a=%h wr=0",
                           c, tr_a[c], tr_wr[c], 32'h100 + c - 1);
      end
    end
  endtask

  task automatic test_load_ext();
    int dc; logic [31:0] d; bit oth;
    set_byte(32'h40, 8'h80); set_byte(32'h41, 8'hFF);
    run_op(1'b0, 1'b0, 2'b00, 1'b1, 32'h40, '0, dc, d, oth);
    n_checks++;
    if (dc !== 3 || d !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb_signed: got cyc=%0d data=%h expected cyc=3 data=ffffff80", dc, d);
    end
    run_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h40, '0, dc, d, oth);
    n_checks++;
    if (dc !== 3 || d !== 32'h0000_0080) begin
      n_fail++; $display("FAIL lbu: got cyc=%0d data=%h expected cyc=3 data=00000080", dc, d);
    end
    run_op(1'b0, 1'b0, 2'b01, 1'b1, 32'h40, '0, dc, d, oth);
    n_checks++;
    if (dc !== 4 || d !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lh_signed: got cyc=%0d data=%h expected cyc=4 data=ffffff80", dc, d);
    end
    run_op(1'b0, 1'b0, 2'b01, 1'b0, 32'h40, '0, dc, d, oth);
    n_checks++;
    if (d !== 32'h0000_FF80) begin n_fail++; $display("FAIL lhu: got %h expected 0000ff80", d); end
  endtask

  task automatic test_store();
    int dc; logic [31:0] d; bit oth;
    logic [31:0] wd;
    wd = 32'hDEAD_BEEF;
    run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h200, wd, dc, d, oth);
    for (int k = 0; k < 4; k++) model[32'h200 + k] = wd[8*k +: 8];
    n_checks++;
    if (dc !== 5 || d !== 32'h0) begin
      n_fail++; $display("FAIL sw_done: got cyc=%0d rdata=%h expected cyc=5 rdata=0", dc, d);
    end
    for (int c = 1; c <= 5; c++) begin
      n_checks++;
      if (tr_wr[c] !== (c <= 4) || (c <= 4 && tr_a[c] !== AW'(32'h200 + c - 1))) begin
        n_fail++; $display("FAIL sw_wr_c%0d: got wr=%b a=%h expected wr=%b", c, tr_wr[c], tr_a[c], c <= 4);
      end
    end
    n_checks++;
    if ({ram[32'h203], ram[32'h202], ram[32'h201], ram[32'h200]} !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sw_bytes: got %h%h%h%h expected deadbeef",
                         ram[32'h203], ram[32'h202], ram[32'h201], ram[32'h200]);
    end
  endtask

  task automatic test_arbitration();
    int mdc, idc;
    logic [31:0] md, id;
    mdc = -1; idc = -1; md = 'x; id = 'x;
    bus.mem_we = 1'b0; bus.mem_len = 2'b10; bus.mem_sign = 1'b0;
    bus.mem_addr = 32'h500; bus.mem_req = 1'b1;
    bus.if_addr = 32'h600; bus.if_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus.mem_done) begin mdc = c; md = bus.mem_rdata; bus.mem_req = 1'b0; end
      if (bus.if_done) begin idc = c; id = bus.if_inst; bus.if_req = 1'b0; break; end
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    tick();
    n_checks++;
    if (mdc !== 6 || md !== exp_load(32'h500, 4, 1'b0)) begin
      n_fail++; $display("FAIL arb_mem_first: got cyc=%0d data=%h expected cyc=6 data=%h", mdc, md, exp_load(32'h500, 4, 1'b0));
    end
    // Fetch is first seen in IDLE at cycle 7, so it completes six cycles later.
    n_checks++;
    if (idc !== 13 || id !== exp_load(32'h600, 4, 1'b0)) begin
      n_fail++; $display("FAIL arb_if_second: got cyc=%0d data=%h expected cyc=13 data=%h", idc, id, exp_load(32'h600, 4, 1'b0));
    end
  endtask

  task automatic test_flush();
    int dc; logic [31:0] d;
    bit seen;
    dc = -1; d = 'x;
    // Flush during READ.
    bus.if_addr = 32'h20; bus.if_req = 1'b1;
    tick(); tick(); tick();
    bus.if_flush = 1'b1;
    tick();
    bus.if_flush = 1'b0;
    n_checks++;
    if (bus.ram_a !== AW'(32'h22) || bus.ram_wr !== 1'b0) begin
      n_fail++; $display("FAIL flush_hold: got a=%h wr=%b expected a=22 wr=0", bus.ram_a, bus.ram_wr);
    end
    bus.if_addr = 32'h8;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.if_done) begin dc = c; d = bus.if_inst; break; end
    end
    bus.if_req = 1'b0;
    tick();
    n_checks++;
    if (dc !== 6 || d !== exp_load(32'h8, 4, 1'b0)) begin
      n_fail++; $display("FAIL flush_refetch: got cyc=%0d data=%h expected cyc=6 data=%h", dc, d, exp_load(32'h8, 4, 1'b0));
    end
    // Flush during DONE.
    bus.if_addr = 32'h30; bus.if_req = 1'b1;
    for (int c = 1; c <= 6; c++) tick();
    bus.if_flush = 1'b1; bus.if_req = 1'b0;
    #1;
    n_checks++;
    if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL flush_in_done: got if_done=%b expected 0", bus.if_done); end
    tick();
    bus.if_flush = 1'b0;
    // Flush in IDLE suppresses the request.
    apply_reset();
    bus.if_addr = 32'h777; bus.if_req = 1'b1; bus.if_flush = 1'b1;
    tick();
    bus.if_req = 1'b0; bus.if_flush = 1'b0;
    seen = (bus.ram_a !== '0);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.if_done !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL flush_in_idle: got fetch activity=1 expected 0"); end
  endtask

  task automatic test_reset_mid_store();
    bit seen;
    apply_reset();
    set_byte(32'h300, 8'h01); set_byte(32'h301, 8'h02);
    set_byte(32'h302, 8'h03); set_byte(32'h303, 8'h04);
    bus.mem_we = 1'b1; bus.mem_len = 2'b10; bus.mem_addr = 32'h300;
    bus.mem_wdata = 32'hDEAD_BEEF; bus.mem_req = 1'b1;
    tick();
    n_checks++;
    if (bus.ram_wr !== 1'b1 || bus.ram_a !== AW'(32'h300)) begin
      n_fail++; $display("FAIL rst_store_start: got wr=%b a=%h expected wr=1 a=300", bus.ram_wr, bus.ram_a);
    end
    rst = 1'b1; bus.mem_req = 1'b0;
    tick();
    n_checks++;
    if (bus.ram_wr !== 1'b0 || bus.mem_done !== 1'b0 || bus.ram_a !== '0 ||
        bus.ram_dout !== 8'h00 || bus.mem_rdata !== '0) begin
      n_fail++; $display("FAIL rst_store_outputs: got wr=%b done=%b a=%h dout=%h rdata=%h expected all 0",
                         bus.ram_wr, bus.mem_done, bus.ram_a, bus.ram_dout, bus.mem_rdata);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.mem_done || bus.ram_wr) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL rst_store_quiet: got activity after reset expected none"); end
    model[32'h300] = 8'hEF;
    n_checks++;
    if ({ram[32'h303], ram[32'h302], ram[32'h301], ram[32'h300]} !== 32'h0403_02EF) begin
      n_fail++; $display("FAIL rst_store_bytes: got %h%h%h%h expected 040302ef",
                         ram[32'h303], ram[32'h302], ram[32'h301], ram[32'h300]);
    end
  endtask

  task automatic test_wrap();
    int dc; logic [31:0] d; bit oth;
    logic [31:0] top;
    top = 32'(MSIZE - 1);
    run_op(1'b0, 1'b1, 2'b10, 1'b0, top, 32'hA1B2_C3D4, dc, d, oth);
    for (int k = 0; k < 4; k++) model[idx(top, k)] = 8'(32'hA1B2_C3D4 >> (8 * k));
    n_checks++;
    if (tr_a[1] !== AW'(top) || tr_a[2] !== '0 || tr_a[4] !== AW'(2)) begin
      n_fail++; $display("FAIL wrap_addr: got %h,%h,%h expected %h,0,2", tr_a[1], tr_a[2], tr_a[4], AW'(top));
    end
    run_op(1'b0, 1'b0, 2'b10, 1'b0, top - 32'd1, '0, dc, d, oth);
    n_checks++;
    if (d !== exp_load(top - 32'd1, 4, 1'b0) || d[23:0] !== 24'hC3D4_00 + 24'(model[top - 1])) begin
      n_fail++; $display("FAIL wrap_load: got %h expected %h", d, exp_load(top - 32'd1, 4, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    int dc, n, wrs, exp_c; logic [31:0] d, a, wd, exp_d; bit oth, sgn, bad;
    int kind;
    logic [1:0] len;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      a[AW-1:0] = ($urandom_range(0, 3) == 0) ? AW'(MSIZE - 1 - $urandom_range(0, 3))
                                               : AW'($urandom_range(0, MSIZE - 1));
      kind = $urandom_range(0, 2);
      len  = 2'($urandom_range(0, 3));
      sgn  = 1'($urandom_range(0, 1));
      wd   = $urandom;
      if (kind == 0) begin
        run_op(1'b1, 1'b0, 2'b10, 1'b0, a, '0, dc, d, oth);
        n = 4; exp_c = 6; exp_d = exp_load(a, 4, 1'b0);
      end else if (kind == 1) begin
        run_op(1'b0, 1'b0, len, sgn, a, '0, dc, d, oth);
        n = nbytes(len); exp_c = n + 2; exp_d = exp_load(a, n, sgn);
      end else begin
        run_op(1'b0, 1'b1, len, 1'b0, a, wd, dc, d, oth);
        n = nbytes(len); exp_c = n + 1; exp_d = '0;
        for (int k = 0; k < n; k++) model[idx(a, k)] = wd[8*k +: 8];
      end
      n_checks++;
      if (dc !== exp_c || d !== exp_d || oth) begin
        n_fail++; $display("FAIL rand_op%0d kind=%0d len=%0d addr=%h: got cyc=%0d data=%h other=%b expected cyc=%0d data=%h",
                           i, kind, n, a, dc, d, oth, exp_c, exp_d);
      end
      wrs = 0;
      for (int c = 1; c <= exp_c && c <= 24; c++) wrs += int'(tr_wr[c]);
      bad = 1'b0;
      for (int k = 0; k <= n; k++) if (ram[idx(a, k)] !== model[idx(a, k)]) bad = 1'b1;
      n_checks++;
      if (wrs !== ((kind == 2) ? n : 0) || bad) begin
        n_fail++; $display("FAIL rand_mem%0d: got writes=%0d ram_ok=%b expected writes=%0d ram_ok=1",
                           i, wrs, !bad, (kind == 2) ? n : 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < MSIZE; i++) begin
      ram[i]   = 8'($urandom);
      model[i] = ram[i];
    end
    test_reset();
    test_fetch();
    test_load_ext();
    test_store();
    apply_reset();
    test_arbitration();
    apply_reset();
    test_flush();
    test_reset_mid_store();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
